// File: rtl/mips_wb_pkg.sv
// Shared constants for the MEM/WB stage: load-type codes, default widths, $zero index.
package mips_wb_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_REG_AW = 5;
    localparam int unsigned LT_W       = 3;
    localparam int unsigned OFF_W      = 2;
    localparam int unsigned REG_ZERO   = 0;

    localparam logic [LT_W-1:0] LT_LW  = 3'd0;
    localparam logic [LT_W-1:0] LT_LB  = 3'd1;
    localparam logic [LT_W-1:0] LT_LBU = 3'd2;
    localparam logic [LT_W-1:0] LT_LH  = 3'd3;
    localparam logic [LT_W-1:0] LT_LHU = 3'd4;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM -> WB handshake bundle: stage controls, MEM-stage result, and register-file write port.
interface mem_wb_stage_if
    import mips_wb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_AW = DEF_REG_AW
);
    logic              stall;
    logic              flush;
    logic              mem_valid;
    logic              mem_regWrite;
    logic              mem_memToReg;
    logic [LT_W-1:0]   mem_loadType;
    logic [OFF_W-1:0]  mem_byteOffset;
    logic [DATA_W-1:0] mem_aluResult;
    logic [DATA_W-1:0] mem_readData;
    logic [REG_AW-1:0] mem_writeRegister;

    logic [REG_AW-1:0] writeRegister;
    logic [DATA_W-1:0] data;
    logic              regWrite;
    logic              wb_valid;
    logic              wb_misalign;

    modport master (
        output stall, flush, mem_valid, mem_regWrite, mem_memToReg, mem_loadType,
               mem_byteOffset, mem_aluResult, mem_readData, mem_writeRegister,
        input  writeRegister, data, regWrite, wb_valid, wb_misalign
    );

    modport slave (
        input  stall, flush, mem_valid, mem_regWrite, mem_memToReg, mem_loadType,
               mem_byteOffset, mem_aluResult, mem_readData, mem_writeRegister,
        output writeRegister, data, regWrite, wb_valid, wb_misalign
    );
endinterface

// File: rtl/load_align.sv
// Little-endian lane select plus sign/zero extension of a raw load word; flags bad alignment.
module load_align
    import mips_wb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] raw,
    input  logic [LT_W-1:0]   load_type,
    input  logic [OFF_W-1:0]  byte_offset,
    output logic [DATA_W-1:0] value,
    output logic              misalign
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b   = raw[{byte_offset, 3'b000} +: 8];
        lane_h   = raw[{byte_offset[1], 4'b0000} +: 16];
        value    = raw;
        misalign = 1'b0;
        // Unused codes 5-7 fall through to the word path.
        case (load_type)
            LT_LB:  value = {{(DATA_W-8){lane_b[7]}}, lane_b};
            LT_LBU: value = {{(DATA_W-8){1'b0}}, lane_b};
            LT_LH: begin
                value    = {{(DATA_W-16){lane_h[15]}}, lane_h};
                misalign = byte_offset[0];
            end
            LT_LHU: begin
                value    = {{(DATA_W-16){1'b0}}, lane_h};
                misalign = byte_offset[0];
            end
            default: misalign = (byte_offset != 2'b00);
        endcase
    end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback select driving the register-file write port.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_stage
    import mips_wb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_AW = DEF_REG_AW
) (
    input  logic                clk,
    input  logic                rst,
    mem_wb_stage_if.slave       bus
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]         retire_count
`endif
);
    logic              valid_q;
    logic              reg_write_q;
    logic              mem_to_reg_q;
    logic [LT_W-1:0]   load_type_q;
    logic [OFF_W-1:0]  byte_offset_q;
    logic [DATA_W-1:0] alu_result_q;
    logic [DATA_W-1:0] read_data_q;
    logic [REG_AW-1:0] write_register_q;

    logic [DATA_W-1:0] load_value;
    logic              load_misalign;
    logic              misalign;

    // Stage register: flush beats stall beats load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.flush) begin
            valid_q          <= 1'b0;
            reg_write_q      <= 1'b0;
            mem_to_reg_q     <= 1'b0;
            load_type_q      <= '0;
            byte_offset_q    <= '0;
            alu_result_q     <= '0;
            read_data_q      <= '0;
            write_register_q <= '0;
        end else if (!bus.stall) begin
            valid_q          <= bus.mem_valid;
            reg_write_q      <= bus.mem_regWrite;
            mem_to_reg_q     <= bus.mem_memToReg;
            load_type_q      <= bus.mem_loadType;
            byte_offset_q    <= bus.mem_byteOffset;
            alu_result_q     <= bus.mem_aluResult;
            read_data_q      <= bus.mem_readData;
            write_register_q <= bus.mem_writeRegister;
        end
    end

    load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .raw         (read_data_q),
        .load_type   (load_type_q),
        .byte_offset (byte_offset_q),
        .value       (load_value),
        .misalign    (load_misalign)
    );

    // Writeback outputs depend only on stage registers.
    always_comb begin
        misalign          = valid_q & mem_to_reg_q & load_misalign;
        bus.wb_valid      = valid_q;
        bus.wb_misalign   = misalign;
        bus.writeRegister = write_register_q;
        bus.data          = mem_to_reg_q ? load_value : alu_result_q;
        bus.regWrite      = valid_q & reg_write_q & ~misalign
                          & (write_register_q != REG_AW'(REG_ZERO));
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_q;

    // An instruction retires on the edge it leaves WB, so a stall holds the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_q <= '0;
        end else if (valid_q && (!bus.stall || bus.flush)) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage with a behavioural writeback model.
`timescale 1ns/1ps
module tb_mem_wb_stage;
    import mips_wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;
    bit   chk_en  = 1'b0;

    always #5 clk = ~clk;

    mem_wb_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_count;
    bit          cnt_model_ok = 1'b1;
    mem_wb_stage dut (.clk(clk), .rst(rst), .bus(bus), .retire_count(retire_count));
`else
    mem_wb_stage dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    // Model state: what WB holds, as captured MEM-stage fields.
    logic        m_valid, m_rw, m_m2r;
    logic [2:0]  m_lt;
    logic [1:0]  m_off;
    logic [31:0] m_alu, m_rd, m_cnt;
    logic [4:0]  m_wreg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {m_valid, m_rw, m_m2r, m_lt, m_off, m_alu, m_rd, m_wreg} <= '0;
            m_cnt <= '0;
        end else begin
            if (m_valid && (!bus.stall || bus.flush)) m_cnt <= m_cnt + 1;
            if (bus.flush)
                {m_valid, m_rw, m_m2r, m_lt, m_off, m_alu, m_rd, m_wreg} <= '0;
            else if (!bus.stall) begin
                m_valid <= bus.mem_valid;     m_rw  <= bus.mem_regWrite;
                m_m2r   <= bus.mem_memToReg;  m_lt  <= bus.mem_loadType;
                m_off   <= bus.mem_byteOffset; m_alu <= bus.mem_aluResult;
                m_rd    <= bus.mem_readData;  m_wreg <= bus.mem_writeRegister;
            end
        end
    end

    function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [2:0] lt,
                                             input logic [1:0] off);
        logic [31:0] sh;
        sh = w >> (8 * int'(off));
        case (lt)
            3'd1: return 32'($signed(sh[7:0]));
            3'd2: return {24'h0, sh[7:0]};
            3'd3: begin sh = w >> (16 * (int'(off) / 2)); return 32'($signed(sh[15:0])); end
            3'd4: begin sh = w >> (16 * (int'(off) / 2)); return {16'h0, sh[15:0]}; end
            default: return w;
        endcase
    endfunction

    function automatic logic bad_align(input logic [2:0] lt, input logic [1:0] off);
        if (lt == 3'd1 || lt == 3'd2) return 1'b0;
        if (lt == 3'd3 || lt == 3'd4) return (int'(off) % 2) != 0;
        return off != 2'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic mis;
        if (chk_en && !rst) begin
            mis = m_valid & m_m2r & bad_align(m_lt, m_off);
            check("cmp_valid", 32'(bus.wb_valid), 32'(m_valid));
            check("cmp_wreg", 32'(bus.writeRegister), 32'(m_wreg));
            check("cmp_data", bus.data, m_m2r ? ext_load(m_rd, m_lt, m_off) : m_alu);
            check("cmp_misalign", 32'(bus.wb_misalign), 32'(mis));
            check("cmp_regwrite", 32'(bus.regWrite),
                  32'(m_valid & m_rw & (m_wreg != 5'd0) & ~mis));
`ifdef WB_RETIRE_CNT_EN
            if (cnt_model_ok) check("cmp_retire", retire_count, m_cnt);
`endif
        end
    end

    task automatic set_in(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                          input logic [1:0] off, input logic [31:0] alu, input logic [31:0] rd,
                          input logic [4:0] wreg);
        bus.mem_valid = v;       bus.mem_regWrite = rw;   bus.mem_memToReg = m2r;
        bus.mem_loadType = lt;   bus.mem_byteOffset = off;
        bus.mem_aluResult = alu; bus.mem_readData = rd;   bus.mem_writeRegister = wreg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_in(0, 0, 0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0);
        repeat (2) tick();
        check("rst_valid", 32'(bus.wb_valid), 32'h0);
        check("rst_regwrite", 32'(bus.regWrite), 32'h0);
        check("rst_data", bus.data, 32'h0);
        check("rst_wreg", 32'(bus.writeRegister), 32'h0);
        check("rst_misalign", 32'(bus.wb_misalign), 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        set_in(1, 1, 0, LT_LW, 2'd0, 32'h0000004D, 32'hDEADBEEF, 5'd12); tick();
        check("alu_regwrite", 32'(bus.regWrite), 32'h1);
        check("alu_wreg", 32'(bus.writeRegister), 32'd12);
        check("alu_data", bus.data, 32'h0000004D);

        set_in(1, 1, 1, LT_LB, 2'd3, 32'h1234, 32'h80FF7F01, 5'd5); tick();
        check("lb_off3", bus.data, 32'hFFFFFF80);
        check("lb_regwrite", 32'(bus.regWrite), 32'h1);
        set_in(1, 1, 1, LT_LBU, 2'd3, 32'h1234, 32'h80FF7F01, 5'd5); tick();
        check("lbu_off3", bus.data, 32'h00000080);
        set_in(1, 1, 1, LT_LH, 2'd2, 32'h1234, 32'h80FF7F01, 5'd5); tick();
        check("lh_off2", bus.data, 32'hFFFF80FF);
        set_in(1, 1, 1, LT_LHU, 2'd0, 32'h1234, 32'h80FF7F01, 5'd5); tick();
        check("lhu_off0", bus.data, 32'h00007F01);
        set_in(1, 1, 1, LT_LB, 2'd1, 32'h1234, 32'h80FF7F01, 5'd5); tick();
        check("lb_off1", bus.data, 32'h0000007F);
        set_in(1, 1, 1, 3'd7, 2'd0, 32'h1234, 32'h80FF7F01, 5'd5); tick();
        check("lt7_as_lw", bus.data, 32'h80FF7F01);

        set_in(1, 1, 0, LT_LW, 2'd0, 32'h55, 32'h0, 5'd0); tick();
        check("zero_regwrite", 32'(bus.regWrite), 32'h0);
        check("zero_data", bus.data, 32'h55);
        set_in(1, 1, 1, LT_LH, 2'd1, 32'h0, 32'h80FF7F01, 5'd3); tick();
        check("lh_off1_misalign", 32'(bus.wb_misalign), 32'h1);
        check("lh_off1_regwrite", 32'(bus.regWrite), 32'h0);
        set_in(1, 1, 1, LT_LW, 2'd2, 32'h0, 32'h80FF7F01, 5'd3); tick();
        check("lw_off2_misalign", 32'(bus.wb_misalign), 32'h1);
        set_in(1, 1, 0, LT_LH, 2'd1, 32'h99, 32'h0, 5'd3); tick();
        check("alu_no_misalign", 32'(bus.wb_misalign), 32'h0);
        check("alu_no_mis_rw", 32'(bus.regWrite), 32'h1);

        set_in(1, 1, 0, LT_LW, 2'd0, 32'd10, 32'h0, 5'd8); tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 1, LT_LB, 2'(i), 32'(100 + i), 32'hA5A5A5A5, 5'(20 + i));
            tick();
            check("stall_wreg", 32'(bus.writeRegister), 32'd8);
            check("stall_data", bus.data, 32'd10);
            check("stall_regwrite", 32'(bus.regWrite), 32'h1);
        end
        bus.flush = 1'b1; tick();
        check("flush_valid", 32'(bus.wb_valid), 32'h0);
        check("flush_regwrite", 32'(bus.regWrite), 32'h0);
        bus.stall = 1'b0; bus.flush = 1'b0;

        set_in(1, 1, 0, LT_LW, 2'd0, 32'h77, 32'h0, 5'd9); tick();
        check("pre_rst_valid", 32'(bus.wb_valid), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.wb_valid), 32'h0);
        check("async_rst_regwrite", 32'(bus.regWrite), 32'h0);
        check("async_rst_data", bus.data, 32'h0);
        check("async_rst_wreg", 32'(bus.writeRegister), 32'h0);
        tick();
        rst = 1'b0;

`ifdef WB_RETIRE_CNT_EN
        set_in(1, 1, 0, LT_LW, 2'd0, 32'h1, 32'h0, 5'd1); tick();
        set_in(1, 1, 0, LT_LW, 2'd0, 32'h2, 32'h0, 5'd2); tick();
        bus.stall = 1'b1; repeat (2) tick(); bus.stall = 1'b0;
        set_in(1, 1, 0, LT_LW, 2'd0, 32'h3, 32'h0, 5'd3); tick();
        set_in(0, 0, 0, LT_LW, 2'd0, 32'h0, 32'h0, 5'd0); tick();
        set_in(1, 1, 0, LT_LW, 2'd0, 32'h4, 32'h0, 5'd4); tick();
        set_in(1, 1, 0, LT_LW, 2'd0, 32'h5, 32'h0, 5'd5); tick();
        set_in(0, 0, 0, LT_LW, 2'd0, 32'h0, 32'h0, 5'd0); repeat (2) tick();
        check("retire_five", retire_count, 32'd5);
        cnt_model_ok = 1'b0;
        force dut.retire_q = 32'hFFFFFFFF;
        #1 release dut.retire_q;
        set_in(1, 1, 0, LT_LW, 2'd0, 32'h6, 32'h0, 5'd6); tick();
        set_in(0, 0, 0, LT_LW, 2'd0, 32'h0, 32'h0, 5'd0); tick();
        check("retire_wrap", retire_count, 32'h0);
`endif

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic of the 5-stage MIPS pipeline.
- Captures the MEM-stage result each cycle.
- Aligns and sign/zero-extends load data, then selects the ALU or load result.
- Drives the register file write port (writeRegister, data, regWrite); the register file commits on its next posedge clk.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width

Ports:
clk  input  1  stage clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
stall  input  1  hold stage contents
flush  input  1  replace incoming instruction with bubble
mem_valid  input  1  MEM stage holds a real instruction
mem_regWrite  input  1  instruction writes a register
mem_memToReg  input  1  1 = result from memory, 0 = ALU
mem_loadType  input  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5-7 treated as LW
mem_byteOffset  input  2  address bits [1:0] of the load
mem_aluResult  input  DATA_W  ALU result
mem_readData  input  DATA_W  raw data-memory word
mem_writeRegister  input  REG_AW  destination register
writeRegister  output  REG_AW  to register file
data  output  DATA_W  writeback value
regWrite  output  1  register file write enable
wb_valid  output  1  WB holds a real instruction
wb_misalign  output  1  misaligned load in WB

Behaviour:
- Async reset: all stage registers cleared. Outputs: wb_valid=0, regWrite=0, writeRegister=0, data=0, wb_misalign=0.
- Edge priority: rst > flush > stall > load.
  - flush: stage becomes a bubble (valid=0, regWrite field=0); other fields don't-care but are cleared.
  - stall (no flush): all stage registers hold.
  - otherwise: capture all mem_* inputs.
- Latency: 1 cycle from MEM inputs to writeback outputs. Outputs are combinational from stage registers only; no input-to-output paths.
- Load alignment (little-endian lanes):
  - LB/LBU: byte [8*off+7 : 8*off], sign- or zero-extended to 32 bits.
  - LH/LHU: halfword selected by off[1], sign- or zero-extended.
  - LW: full word.
- Misalignment:
  - wb_misalign = wb_valid & memToReg & ((halfword load & off[0]) | (word load & off != 0)).
  - A misaligned load never writes.
- data = memToReg ? aligned load : aluResult. Valid even when regWrite=0.
- regWrite = wb_valid & wb_regWrite & (writeRegister != 0) & ~wb_misalign. Writes to $zero are suppressed.
- Stalled cycles re-present an identical write; the repeated write is idempotent.
- stall and flush in the same cycle: flush wins.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined:
  - Extra output retire_count (32 bits, reset 0).
  - Increments on a posedge when wb_valid=1 and (stall=0 or flush=1), so each instruction is counted exactly once.
  - Wraps 0xFFFFFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package mips_wb_pkg:
  - load-type constants LT_LW, LT_LB, LT_LBU, LT_LH, LT_LHU;
  - DATA_W / REG_AW defaults;
  - REG_ZERO constant.
- Sub-module load_align (combinational):
  - inputs: raw word, loadType, byteOffset;
  - outputs: extended value, misalign flag.
- The stage registers and the counter stay in mem_wb_stage.

Test Plan:
- Reset mid-operation: assert rst with wb_valid=1 -> wb_valid, regWrite, data, writeRegister are 0 immediately, before the next edge.
- ALU write: mem_aluResult=0x0000004D, reg 12, regWrite=1, memToReg=0 -> next cycle regWrite=1, writeRegister=12, data=0x4D.
- LB: readData=0x80FF7F01, off=3, LB -> data=0xFFFFFF80. Same with LBU -> 0x00000080. Same with LH, off=2 -> 0xFFFF80FF.
- $zero / misalign: write to reg 0 -> regWrite=0. LH with off=1 -> wb_misalign=1, regWrite=0.
- Stall then flush:
  - Load reg 8 = 10, then stall 3 cycles with changing inputs -> outputs hold reg 8 / 10.
  - Assert stall and flush together -> next cycle wb_valid=0, regWrite=0.
- WB_RETIRE_CNT_EN:
  - 5 valid instructions, 2 stall cycles, 1 bubble -> retire_count=5.
  - Preload counter near wrap (force 0xFFFFFFFF), retire one -> 0.
